rvga_membus_arbiter: RTL
========================

// Module: rvga_membus_arbiter
// PURPOSE
//  Round-robin arbiter joining NUM_MASTERS memory-bus masters onto one memory-bus slave.
//  Uses the rvga membus protocol (addr/read/write/wdata -> rdata/resp), widened by parameters.
//  Adds a byte write mask, a response timeout and an error flag.
//  Sits between fetch/LSU/debug requesters and the single memory/MMIO slave.
// PARAMETERS
//  NUM_MASTERS  2   number of requesting masters, >=2
//  ADDR_W       32  address width
//  DATA_W       32  data width, multiple of 8
//  TIMEOUT      256 cycles in BUSY without s_resp_i before abort; 0 disables the timeout
// PORTS
//  clk_i        in   1                      clock, rising edge
//  reset_i      in   1                      async reset, active-high
//  m_addr_i     in   NUM_MASTERS*ADDR_W     per-master address, master k at [k*ADDR_W +: ADDR_W]
//  m_read_i     in   NUM_MASTERS            per-master read request
//  m_write_i    in   NUM_MASTERS            per-master write request
//  m_wdata_i    in   NUM_MASTERS*DATA_W     per-master write data
//  m_wmask_i    in   NUM_MASTERS*DATA_W/8   per-master byte write enables
//  m_rdata_o    out  DATA_W                 read data, shared by all masters, valid with m_resp_o
//  m_resp_o     out  NUM_MASTERS            one-hot response pulse
//  m_err_o      out  1                      error flag, valid with m_resp_o (timeout)
//  s_addr_o     out  ADDR_W                 slave address
//  s_read_o     out  1                      slave read
//  s_write_o    out  1                      slave write
//  s_wdata_o    out  DATA_W                 slave write data
//  s_wmask_o    out  DATA_W/8               slave byte enables
//  s_rdata_i    in   DATA_W                 slave read data
//  s_resp_i     in   1                      slave response, 1-cycle pulse
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, grant=0, all outputs 0, timeout counter 0.
//  Masters hold read/write and their fields stable from assertion until they sample m_resp_o.
//  A master asserting both read and write is treated as a read; the write fields are ignored.
//  IDLE:
//   - A request is m_read_i[k]|m_write_i[k].
//   - The first requester at or after ptr, wrapping modulo NUM_MASTERS, wins.
//   - Latch grant=k and its addr/read/write/wdata/wmask; go to BUSY.
//   - No request: stay in IDLE.
//  BUSY:
//   - Drive s_* from the latched registers; the slave sees the request 1 cycle after IDLE arbitration.
//   - Count cycles.
//   - s_resp_i=1: latch rdata=s_rdata_i and err=0; deassert s_read_o/s_write_o; go to RESP.
//   - Count reaches TIMEOUT (TIMEOUT!=0): latch rdata=0 and err=1; deassert s_*; go to RESP.
//   - If s_resp_i and the timeout occur in the same cycle, s_resp_i wins (err=0).
//  RESP:
//   - m_resp_o = 1<<grant for exactly one cycle; m_rdata_o and m_err_o hold the latched values.
//   - ptr <= (grant+1) mod NUM_MASTERS; go to IDLE.
//   - This cycle lets the master drop its request before the next arbitration, so there is no re-issue.
//  s_resp_i outside BUSY (late slave reply after an abort) is ignored.
//  m_rdata_o/m_err_o hold their last value outside RESP; m_resp_o=0 outside RESP.
//  Minimum transaction: IDLE -> BUSY (slave resp in first BUSY cycle) -> RESP = 3 cycles; 1 bus op per 3 cycles max.
//  Fairness: a waiting master is granted within NUM_MASTERS-1 other transactions.
//  reset_i mid-transaction: immediate return to reset values; the in-flight op is dropped and no m_resp_o is issued.
//  Timeout counter: clog2(TIMEOUT+1) bits, cleared on IDLE->BUSY, saturates.
// STRUCTURE
//  rvga_types package additions:
//   - membus_arb_state_e {ARB_IDLE, ARB_BUSY, ARB_RESP}
//   - typedef struct membus_req_t {addr, read, write, wdata, wmask} for the latched request
//  Sub-module rvga_rr_picker: combinational; inputs req[N] and ptr; outputs valid and idx (first set bit
//   at or after ptr, wrapping). Kept separate so it can be reused and unit-tested.
//  Top: state register, request latch, timeout counter, response registers.
// TESTING
//  1 Single master 0 read addr=0x100; slave resp 2 cycles after s_read_o with rdata=0xCAFEF00D
//    -> m_resp_o=01 for 1 cycle, m_rdata_o=0xCAFEF00D, m_err_o=0.
//  2 N=4, all masters request continuously -> grant order 0,1,2,3,0; each m_resp_o one-hot, never repeated back to back.
//  3 Master 1 write wdata=0x11223344 wmask=0b0101 -> s_wdata_o/s_wmask_o match, s_read_o=0, m_resp_o=10.
//  4 TIMEOUT=8, slave silent -> s_read_o drops after 8 BUSY cycles; m_resp_o pulses, m_err_o=1, m_rdata_o=0.
//    A late s_resp_i is ignored.
//  5 s_resp_i and timeout in the same cycle -> m_err_o=0, rdata=s_rdata_i.
//  6 reset_i asserted mid-BUSY -> all outputs 0 asynchronously, no m_resp_o.
//    After release, ptr=0 and master 0 wins the first arbitration.

Source files
------------

// File: rtl/rvga_membus_arbiter_pkg.sv
// Shared types and width helpers for the rvga memory-bus arbiter.
package rvga_membus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } membus_arb_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // The counter must be able to hold TIMEOUT itself; a disabled timeout still gets one bit.
   function automatic int cnt_width(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/rvga_membus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rvga_rr_picker #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      int cand;
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = 0;
      // Walk from the farthest offset down so the nearest requester is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         cand = int'(ptr_i) + i;
         if (cand >= N) cand = cand - N;
         if (req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/rvga_membus_arbiter.sv
// Round-robin arbiter joining NUM_MASTERS membus masters onto one slave, with byte mask and response timeout.
module rvga_membus_arbiter
   import rvga_membus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT     = 256
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
   input  logic [NUM_MASTERS-1:0]          m_read_i,
   input  logic [NUM_MASTERS-1:0]          m_write_i,
   input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
   input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wmask_i,
   output logic [DATA_W-1:0]               m_rdata_o,
   output logic [NUM_MASTERS-1:0]          m_resp_o,
   output logic                            m_err_o,
   output logic [ADDR_W-1:0]               s_addr_o,
   output logic                            s_read_o,
   output logic                            s_write_o,
   output logic [DATA_W-1:0]               s_wdata_o,
   output logic [DATA_W/8-1:0]             s_wmask_o,
   input  logic [DATA_W-1:0]               s_rdata_i,
   input  logic                            s_resp_i
);

   localparam int IDX_W  = idx_width(NUM_MASTERS);
   localparam int MASK_W = DATA_W / 8;
   localparam int CNT_W  = cnt_width(TIMEOUT);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              read;
      logic              write;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] wmask;
   } membus_req_t;

   membus_arb_state_e      state_q;
   logic [IDX_W-1:0]       ptr_q;
   logic [IDX_W-1:0]       grant_q;
   membus_req_t            req_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [DATA_W-1:0]      rdata_q;
   logic                   err_q;
   logic [NUM_MASTERS-1:0] resp_q;

   logic [NUM_MASTERS-1:0] req_vec;
   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;
   membus_req_t            pick_req;
   logic                   timeout_hit;

   assign req_vec = m_read_i | m_write_i;

   rvga_rr_picker #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i   (req_vec),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // Read wins over write; the write fields of a read request are dropped.
   always_comb begin
      pick_req = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (pick_idx == IDX_W'(k)) begin
            pick_req.addr  = m_addr_i[k*ADDR_W +: ADDR_W];
            pick_req.read  = m_read_i[k];
            pick_req.write = m_write_i[k] & ~m_read_i[k];
            if (m_write_i[k] && !m_read_i[k]) begin
               pick_req.wdata = m_wdata_i[k*DATA_W +: DATA_W];
               pick_req.wmask = m_wmask_i[k*MASK_W +: MASK_W];
            end
         end
      end
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         req_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         resp_q  <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               resp_q <= '0;
               if (pick_valid) begin
                  grant_q <= pick_idx;
                  req_q   <= pick_req;
                  cnt_q   <= '0;
                  state_q <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
               // A slave reply in the timeout cycle still counts as a normal completion.
               if (s_resp_i) begin
                  rdata_q <= s_rdata_i;
                  err_q   <= 1'b0;
                  req_q   <= '0;
                  resp_q  <= NUM_MASTERS'(1) << grant_q;
                  state_q <= ARB_RESP;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  req_q   <= '0;
                  resp_q  <= NUM_MASTERS'(1) << grant_q;
                  state_q <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               resp_q  <= '0;
               ptr_q   <= (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
               state_q <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign m_rdata_o = rdata_q;
   assign m_resp_o  = resp_q;
   assign m_err_o   = err_q;
   assign s_addr_o  = req_q.addr;
   assign s_read_o  = req_q.read;
   assign s_write_o = req_q.write;
   assign s_wdata_o = req_q.wdata;
   assign s_wmask_o = req_q.wmask;

endmodule
